// File: rtl/fact_pkg.sv
// rtl/fact_pkg.sv - shared state encoding and default widths for the factorial engine
//
// Purpose : FSM state type and default datapath widths used by fact_ctrl and
//           fact_engine.
// Contents: state_t (3-bit enum), FACT_WIDTH, FACT_NW.

package fact_pkg;

    localparam int FACT_WIDTH = 32;
    localparam int FACT_NW    = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_MUL   = 3'd2,
        ST_DEC   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/fact_ctrl.sv
// rtl/fact_ctrl.sv - control FSM sequencing the factorial multiply/decrement loop
//
// Purpose : walks IDLE -> CHECK -> (MUL -> DEC -> CHECK)* -> DONE and issues
//           one-cycle enables to the datapath in the top level.
// Ports   : clk, rst_n   clock, async active-low reset
//           go, abort    start strobe / cancel request
//           cnt_gt1      datapath counter is greater than one
//           load         capture operand, initialise product and overflow
//           mul_en       update product with product * counter
//           dec_en       decrement counter
//           latch        copy product/overflow into the result registers
//           busy, done   status decoded from the state register

module fact_ctrl
    import fact_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic go,
    input  logic abort,
    input  logic cnt_gt1,
    output logic load,
    output logic mul_en,
    output logic dec_en,
    output logic latch,
    output logic busy,
    output logic done
);

    state_t r_state;
    state_t w_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Abort is checked first in every working state so that a cancelled
    // computation never reaches the result registers.
    always_comb begin
        w_next = r_state;
        load   = 1'b0;
        mul_en = 1'b0;
        dec_en = 1'b0;
        latch  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (go && !abort) begin
                    load   = 1'b1;
                    w_next = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (abort) begin
                    w_next = ST_IDLE;
                end else if (cnt_gt1) begin
                    w_next = ST_MUL;
                end else begin
                    latch  = 1'b1;
                    w_next = ST_DONE;
                end
            end
            ST_MUL: begin
                if (abort) begin
                    w_next = ST_IDLE;
                end else begin
                    mul_en = 1'b1;
                    w_next = ST_DEC;
                end
            end
            ST_DEC: begin
                if (abort) begin
                    w_next = ST_IDLE;
                end else begin
                    dec_en = 1'b1;
                    w_next = ST_CHECK;
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    assign busy = (r_state != ST_IDLE);
    assign done = (r_state == ST_DONE);

endmodule

// File: rtl/fact_engine.sv
// rtl/fact_engine.sv - iterative n! engine with overflow flag, abort and done pulse
//
// Purpose : computes n! mod 2^WIDTH by repeated multiply/decrement and flags
//           whether the true factorial exceeded WIDTH bits.
// Ports   : clk, rst_n   clock, async active-low reset
//           go, n        start strobe and operand (sampled only when idle)
//           abort        cancel the running computation
//           busy         high whenever the engine is not idle
//           done         one-cycle completion pulse
//           result       n! mod 2^WIDTH, held until the next completion
//           overflow     true n! did not fit in WIDTH bits, held with result

module fact_engine
    import fact_pkg::*;
#(
    parameter int WIDTH = FACT_WIDTH,
    parameter int NW    = FACT_NW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             go,
    input  logic [NW-1:0]    n,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             overflow
);

    localparam logic [NW-1:0]    CNT_ONE  = NW'(1);
    localparam logic [WIDTH-1:0] PROD_ONE = WIDTH'(1);

    logic [NW-1:0]       r_cnt;
    logic [WIDTH-1:0]    r_prod;
    logic                r_ovf;
    logic [WIDTH-1:0]    r_result;
    logic                r_overflow;

    logic                w_load;
    logic                w_mul_en;
    logic                w_dec_en;
    logic                w_latch;
    logic                w_cnt_gt1;
    logic [WIDTH+NW-1:0] w_prod_ext;
    logic [WIDTH+NW-1:0] w_cnt_ext;
    logic [WIDTH+NW-1:0] w_full;
    logic [NW-1:0]       w_full_hi;

    fact_ctrl u_ctrl (
        .clk     (clk),
        .rst_n   (rst_n),
        .go      (go),
        .abort   (abort),
        .cnt_gt1 (w_cnt_gt1),
        .load    (w_load),
        .mul_en  (w_mul_en),
        .dec_en  (w_dec_en),
        .latch   (w_latch),
        .busy    (busy),
        .done    (done)
    );

    assign w_cnt_gt1  = (r_cnt > CNT_ONE);

    // Full-width product: any bit above WIDTH means the true factorial has
    // left the representable range, and since the multiplier never shrinks
    // that condition stays true for the rest of the computation.
    assign w_prod_ext = {{NW{1'b0}}, r_prod};
    assign w_cnt_ext  = {{WIDTH{1'b0}}, r_cnt};
    assign w_full     = w_prod_ext * w_cnt_ext;
    assign w_full_hi  = w_full[WIDTH+NW-1:WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_prod     <= '0;
            r_ovf      <= 1'b0;
            r_result   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_load) begin
                r_cnt  <= n;
                r_prod <= PROD_ONE;
                r_ovf  <= 1'b0;
            end
            if (w_mul_en) begin
                r_prod <= w_full[WIDTH-1:0];
                r_ovf  <= r_ovf | (|w_full_hi);
            end
            if (w_dec_en) begin
                r_cnt <= r_cnt - CNT_ONE;
            end
            if (w_latch) begin
                r_result   <= r_prod;
                r_overflow <= r_ovf;
            end
        end
    end

    assign result   = r_result;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_fact_engine.sv
// tb/tb_fact_engine.sv - self-checking bench for fact_engine at WIDTH=32 and WIDTH=8

module tb_fact_engine;

    logic        clk;
    logic        rst_n;
    logic        go;
    logic [3:0]  n;
    logic        abort;

    logic        busy32, done32, ov32;
    logic [31:0] res32;
    logic        busy8, done8, ov8;
    logic [7:0]  res8;

    int checks   = 0;
    int failures = 0;

    logic [31:0] last32;
    logic [7:0]  last8;

    fact_engine #(.WIDTH(32), .NW(4)) u32 (
        .clk(clk), .rst_n(rst_n), .go(go), .n(n), .abort(abort),
        .busy(busy32), .done(done32), .result(res32), .overflow(ov32)
    );

    fact_engine #(.WIDTH(8), .NW(4)) u8 (
        .clk(clk), .rst_n(rst_n), .go(go), .n(n), .abort(abort),
        .busy(busy8), .done(done8), .result(res8), .overflow(ov8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic longint unsigned fact(input int nv);
        longint unsigned f = 1;
        for (int i = 2; i <= nv; i++) f = f * longint'(i);
        return f;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Starts an operation in the current (idle) cycle, follows it to done and
    // checks timing and values for both widths; leaves the bench in the idle
    // cycle after done so the next operation can start back-to-back.
    task automatic run_op(input int nv, input bit pulse_go);
        int  exp_cyc;
        int  cyc;
        bit  seen;
        bit  busy_ok;
        longint unsigned f;
        exp_cyc = 2 + 3 * ((nv > 1) ? nv - 1 : 0);
        f = fact(nv);
        go = 1'b1;
        n  = 4'(nv);
        step;
        go = 1'b0;
        cyc = 1;
        seen = 0;
        busy_ok = 1;
        while (!seen && cyc <= 60) begin
            if (!busy32 || !busy8) busy_ok = 0;
            if (pulse_go && cyc == 3 && exp_cyc > 4) begin
                go = 1'b1;
                n  = 4'($urandom_range(0, 15));
            end else begin
                go = 1'b0;
            end
            if (done32) seen = 1;
            else begin
                step;
                cyc++;
            end
        end
        go = 1'b0;
        check($sformatf("done_seen n=%0d", nv), 64'(seen), 64'd1);
        check($sformatf("done_cycle n=%0d", nv), 64'(cyc), 64'(exp_cyc));
        check($sformatf("busy_during n=%0d", nv), 64'(busy_ok), 64'd1);
        check($sformatf("done8 n=%0d", nv), 64'(done8), 64'd1);
        check($sformatf("result32 n=%0d", nv), 64'(res32), f & 64'hFFFF_FFFF);
        check($sformatf("overflow32 n=%0d", nv), 64'(ov32), 64'(f > 64'hFFFF_FFFF));
        check($sformatf("result8 n=%0d", nv), 64'(res8), f & 64'hFF);
        check($sformatf("overflow8 n=%0d", nv), 64'(ov8), 64'(f > 64'hFF));
        last32 = 32'(f & 64'hFFFF_FFFF);
        last8  = 8'(f & 64'hFF);
        step;
        check($sformatf("busy_after n=%0d", nv), 64'(busy32 | busy8), 64'd0);
        check($sformatf("done_after n=%0d", nv), 64'(done32 | done8), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        go    = 1'b0;
        abort = 1'b0;
        n     = 4'd0;
        last32 = 32'd0;
        last8  = 8'd0;
        repeat (2) step;
        check("reset_busy", 64'(busy32 | busy8), 64'd0);
        check("reset_done", 64'(done32 | done8), 64'd0);
        check("reset_result", 64'(res32 | 32'(res8)), 64'd0);
        check("reset_overflow", 64'(ov32 | ov8), 64'd0);
        rst_n = 1'b1;
        step;

        // Directed values from the plan, with go pulses during busy on one.
        run_op(5, 1);
        run_op(0, 0);
        run_op(1, 0);
        run_op(6, 0);
        run_op(12, 1);
        run_op(13, 0);
        run_op(15, 0);

        // Abort in MUL after a prior n=3 result; go while busy is ignored.
        run_op(3, 0);
        go = 1'b1; n = 4'd7;
        step;
        go = 1'b1; n = 4'd2;
        step;
        go = 1'b0; abort = 1'b1;
        step;
        abort = 1'b0;
        check("abort_mul_busy", 64'(busy32 | busy8), 64'd0);
        check("abort_mul_done", 64'(done32 | done8), 64'd0);
        check("abort_mul_result32", 64'(res32), 64'(last32));
        check("abort_mul_result8", 64'(res8), 64'(last8));
        repeat (3) step;
        check("abort_no_queue", 64'(busy32 | done32), 64'd0);

        // Abort in CHECK.
        go = 1'b1; n = 4'd9;
        step;
        go = 1'b0; abort = 1'b1;
        step;
        abort = 1'b0;
        check("abort_check_busy", 64'(busy32), 64'd0);
        check("abort_check_result", 64'(res32), 64'(last32));

        // go and abort together in IDLE: nothing starts.
        go = 1'b1; abort = 1'b1; n = 4'd5;
        step;
        go = 1'b0; abort = 1'b0;
        check("go_abort_idle", 64'(busy32 | busy8), 64'd0);

        // Abort during DONE: pulse and result still appear.
        go = 1'b1; n = 4'd4;
        step;
        go = 1'b0;
        repeat (10) step;
        check("abort_done_pulse", 64'(done32), 64'd1);
        check("abort_done_result", 64'(res32), 64'd24);
        abort = 1'b1;
        step;
        abort = 1'b0;
        check("abort_done_idle", 64'(busy32 | done32), 64'd0);

        // Asynchronous reset between edges mid-computation.
        go = 1'b1; n = 4'd6;
        step;
        go = 1'b0;
        step;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_busy", 64'(busy32 | busy8), 64'd0);
        check("async_done", 64'(done32 | done8), 64'd0);
        check("async_result", 64'(res32 | 32'(res8)), 64'd0);
        check("async_overflow", 64'(ov32 | ov8), 64'd0);
        step;
        step;
        rst_n = 1'b1;
        step;
        check("async_no_done", 64'(done32 | busy32), 64'd0);
        run_op(4, 0);

        // Randomised operands against the factorial model.
        for (int k = 0; k < 25; k++) begin
            run_op(int'($urandom_range(0, 15)), bit'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

endmodule
